avg_share_ctrl: RTL and testbench
=================================

# avg_share_ctrl

Controller that time-shares one moving-average datapath (8-bit `data` in; `valid`/`out` back) between two sample requesters. It grants whole frames in round-robin order. Before each frame it clears the datapath, streams FRAME_LEN samples from the granted requester, and collects OUT_LEN results tagged with the owner. It then pulses `done`. It sits between the sample sources and the averager, and performs the reset and stimulus sequencing a testbench would otherwise perform.

## Interface
- FRAME_LEN, 128, samples streamed per frame
- OUT_LEN, 120, averager results collected per frame (FRAME_LEN minus window warm-up)
- DRAIN_MAX, 16, cycles allowed after the last sample for the remaining results

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- req  in  2  per-requester frame request; sampled only in IDLE
- din0  in  8  requester 0 sample; must be valid in every cycle where gnt[0]=1
- din1  in  8  requester 1 sample; must be valid in every cycle where gnt[1]=1
- gnt  out  2  one-hot; high for exactly FRAME_LEN consecutive cycles per frame
- avg_rst  out  1  reset to the averager
- avg_data  out  8  sample to the averager
- avg_valid  in  1  averager result strobe
- avg_out  in  8  averager result
- out_valid  out  1  forwarded result strobe
- out_data  out  8  forwarded result
- out_id  out  1  owner of the forwarded result
- done  out  2  one-cycle pulse at the owner's index when its frame completes
- timeout  out  1  sticky; set when DRAIN expires early; cleared only by reset
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE. All outputs are registered.
- IDLE: if req≠0, latch the owner and go to CLEAR.
  - Owner selection: a single requester wins outright. If both request, the winner is the requester not in `last`.
  - `last` resets to 1, so requester 0 wins the first tie.
- CLEAR (1 cycle): avg_rst=1, sample_cnt=0, res_cnt=0. Next state is STREAM.
- STREAM (FRAME_LEN cycles):
  - gnt[owner]=1.
  - Each cycle, capture din_owner into avg_data and increment sample_cnt.
  - When sample_cnt reaches FRAME_LEN-1, go to DRAIN.
- DRAIN:
  - Go to DONE when res_cnt reaches OUT_LEN.
  - Otherwise go to DONE after DRAIN_MAX cycles and set `timeout`.
- DONE (1 cycle): done[owner]=1, last←owner. Next state is IDLE.
- Result capture:
  - Active in STREAM and DRAIN, only while avg_rst=0 and res_cnt<OUT_LEN.
  - On avg_valid=1: out_valid=1, out_data=avg_out, out_id=owner, res_cnt+1.
  - Results beyond OUT_LEN, and avg_valid while avg_rst=1 or in IDLE/CLEAR/DONE, are dropped.
- If res_cnt reaches OUT_LEN during STREAM, STREAM still completes all FRAME_LEN samples before going to DONE (DRAIN is skipped).
- Dropping req mid-frame does not abort the frame. The next frame is arbitrated only after returning to IDLE.
- Counter widths: sample_cnt and res_cnt are clog2(FRAME_LEN+1) bits and never wrap. The drain counter is clog2(DRAIN_MAX+1) bits.

## Timing
- Reset values:
  - state=IDLE, gnt=0, avg_rst=1, avg_data=0
  - out_valid=0, out_data=0, out_id=0
  - done=0, timeout=0, busy=0, last=1
- avg_rst stays 1 through IDLE and CLEAR. It drops on the first STREAM cycle.
- Reset asserted mid-frame: on the next edge all state returns to reset values. The partial frame produces no done pulse.
- Frame cadence:
  - Edge E: req seen in IDLE.
  - E+1: CLEAR.
  - E+2 … E+FRAME_LEN+1: gnt high.
  - din captured at edge k appears on avg_data from k+1.
  - DONE follows the last result capture by 1 cycle. done is visible for exactly one cycle.
- Result path latency: avg_valid/avg_out at edge k → out_valid/out_data at k+1.
- Minimum overhead per frame: 3 cycles (IDLE, CLEAR, DONE) plus drain time. Back-to-back requests therefore never overlap gnt.

## Test plan
- Requester 0 alone, din0=0x00..0x7F ramp, averager model = 9-tap mean → gnt[0] high 128 cycles; avg_data replays ramp 1 cycle late; 120 out_valid with out_id=0; done=2'b01 once; timeout=0.
- req=2'b11 held from reset → frame order 0,1,0,1. gnt never overlaps. avg_rst pulses before each frame.
- Averager returns only 110 results → DRAIN expires after 16 cycles; timeout=1; done still pulses; out_valid count is 110.
- Averager returns 125 results → exactly 120 forwarded; extras dropped; next frame unaffected.
- Reset asserted at sample 60 of a frame → next edge: gnt=0, avg_rst=1, busy=0, no done. A new request restarts with requester 0 winning the tie.
- avg_valid forced high while idle and during CLEAR → no out_valid.

Source files
------------

// File: rtl/avg_share_ctrl.sv
// avg_share_ctrl: round-robin frame arbiter that time-shares one moving-average
// datapath between two sample requesters (clear, stream, collect, done).
module avg_share_ctrl #(
  parameter int FRAME_LEN = 128,
  parameter int OUT_LEN   = 120,
  parameter int DRAIN_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] din0,
  input  logic [7:0] din1,
  output logic [1:0] gnt,
  output logic       avg_rst,
  output logic [7:0] avg_data,
  input  logic       avg_valid,
  input  logic [7:0] avg_out,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_id,
  output logic [1:0] done,
  output logic       timeout,
  output logic       busy
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int DW = $clog2(DRAIN_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CW-1:0] SAMPLE_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] RES_FULL    = CW'(OUT_LEN);
  localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_MAX - 1);

  logic [2:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] sample_cnt_q, sample_cnt_d;
  logic [CW-1:0] res_cnt_q, res_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          avg_rst_q, avg_rst_d;
  logic [7:0]    avg_data_q, avg_data_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_id_q, out_id_d;
  logic [1:0]    done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    sample_cnt_d = sample_cnt_q;
    res_cnt_d    = res_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    avg_data_d   = avg_data_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE: begin
        // On a tie the requester that did not own the previous frame wins
        if (req != 2'b00) begin
          owner_d = (req == 2'b11) ? ~last_q : req[1];
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        sample_cnt_d = '0;
        res_cnt_d    = '0;
        drain_cnt_d  = '0;
        state_d      = S_STREAM;
      end
      S_STREAM: begin
        avg_data_d   = owner_q ? din1 : din0;
        sample_cnt_d = sample_cnt_q + CW'(1);
        if (sample_cnt_q == SAMPLE_LAST)
          state_d = (res_cnt_q == RES_FULL) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (res_cnt_q == RES_FULL) begin
          state_d = S_DONE;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Results are only accepted while the averager is out of reset and the frame quota is open
    if ((state_q == S_STREAM || state_q == S_DRAIN) && !avg_rst_q &&
        (res_cnt_q < RES_FULL) && avg_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = avg_out;
      out_id_d    = owner_q;
      res_cnt_d   = res_cnt_q + CW'(1);
    end

    gnt_d     = (state_d == S_STREAM) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    avg_rst_d = !(state_d == S_STREAM || state_d == S_DRAIN);
    done_d    = (state_d == S_DONE) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      sample_cnt_q <= '0;
      res_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      gnt_q        <= 2'b00;
      avg_rst_q    <= 1'b1;
      avg_data_q   <= 8'h00;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_id_q     <= 1'b0;
      done_q       <= 2'b00;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      sample_cnt_q <= sample_cnt_d;
      res_cnt_q    <= res_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      gnt_q        <= gnt_d;
      avg_rst_q    <= avg_rst_d;
      avg_data_q   <= avg_data_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign avg_rst   = avg_rst_q;
  assign avg_data  = avg_data_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_avg_share_ctrl.sv
// Testbench for avg_share_ctrl: drives frames through a behavioural 9-tap averager
// and checks forwarded results, arbitration order, drain timeout and reset behaviour.
module tb_avg_share_ctrl;
  localparam int FRAME_LEN = 128;
  localparam int OUT_LEN   = 120;
  localparam int DRAIN_MAX = 16;
  localparam int TAPS      = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] din0 = 8'h00, din1 = 8'h00;
  logic       avg_valid = 1'b0;
  logic [7:0] avg_out = 8'h00;
  logic [1:0] gnt, done;
  logic       avg_rst, out_valid, out_id, timeout, busy;
  logic [7:0] avg_data, out_data;

  avg_share_ctrl #(.FRAME_LEN(FRAME_LEN), .OUT_LEN(OUT_LEN), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .reset(reset), .req(req), .din0(din0), .din1(din1), .gnt(gnt),
    .avg_rst(avg_rst), .avg_data(avg_data), .avg_valid(avg_valid), .avg_out(avg_out),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .done(done),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  logic [7:0] src0[$], src1[$], win[$], avgDataQ[$];
  logic [8:0] outQ[$], expQ[$];
  logic [1:0] doneQ[$];
  bit orderQ[$], rstOkQ[$];
  int runQ[$];
  int idx0 = 0, idx1 = 0, emitted = 0, resultLimit = OUT_LEN, extraCount = 0, extraLeft = 0;
  int gntCnt0 = 0, gntCnt1 = 0, runLen = 0;
  int lastOutCyc = 0, doneCyc = 0, gntRiseCyc = 0, gntFallCyc = 0;
  bit forceValid = 0, prevGnt = 0, lastAvgRst = 1, overlap = 0, dropReq = 0;

  // One clock: observe outputs, play the averager, drive the granted requester's sample
  task automatic cycle();
    int sum;
    bit pushed;
    @(posedge clk);
    #1;
    cyc++;
    pushed = 0;
    if (prevGnt) begin
      win.push_back(avg_data);
      avgDataQ.push_back(avg_data);
      pushed = 1;
    end
    if (avg_rst) begin
      win.delete();
      emitted = 0;
    end
    if (out_valid) begin
      outQ.push_back({out_id, out_data});
      lastOutCyc = cyc;
    end
    if (done != 2'b00) begin
      doneQ.push_back(done);
      doneCyc = cyc;
    end
    if (gnt == 2'b11) overlap = 1;
    if (gnt != 2'b00 && !prevGnt) begin
      orderQ.push_back(gnt[1]);
      rstOkQ.push_back(lastAvgRst && !avg_rst);
      gntRiseCyc = cyc;
      runLen = 0;
    end
    if (gnt != 2'b00) runLen++;
    if (gnt == 2'b00 && prevGnt) begin
      runQ.push_back(runLen);
      gntFallCyc = cyc;
    end
    if (gnt[0]) gntCnt0++;
    if (gnt[1]) gntCnt1++;

    if (forceValid) begin
      avg_valid = 1'b1;
      avg_out = 8'($urandom);
    end else if (pushed && !avg_rst && win.size() >= TAPS && emitted < resultLimit) begin
      sum = 0;
      for (int k = win.size() - TAPS; k < win.size(); k++) sum += int'(win[k]);
      avg_valid = 1'b1;
      avg_out = 8'(sum / TAPS);
      emitted++;
      if (emitted == OUT_LEN) extraLeft = extraCount;
    end else if (extraLeft > 0) begin
      avg_valid = 1'b1;
      avg_out = 8'hEE;
      extraLeft--;
    end else begin
      avg_valid = 1'b0;
      avg_out = 8'($urandom);
    end

    if (gnt[0] && idx0 < src0.size()) din0 = src0[idx0++];
    else din0 = 8'($urandom);
    if (gnt[1] && idx1 < src1.size()) din1 = src1[idx1++];
    else din1 = 8'($urandom);
    prevGnt = (gnt != 2'b00);
    lastAvgRst = avg_rst;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic resetPulse();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic clearLogs();
    src0.delete(); src1.delete(); win.delete(); avgDataQ.delete();
    outQ.delete(); expQ.delete(); doneQ.delete(); orderQ.delete();
    rstOkQ.delete(); runQ.delete();
    idx0 = 0; idx1 = 0; gntCnt0 = 0; gntCnt1 = 0; overlap = 0;
    extraLeft = 0; extraCount = 0; resultLimit = OUT_LEN;
    lastOutCyc = 0; doneCyc = 0; gntRiseCyc = 0; gntFallCyc = 0;
  endtask

  task automatic fillRandom(input bit id, input int n);
    for (int i = 0; i < n; i++) begin
      if (id) src1.push_back(8'($urandom));
      else src0.push_back(8'($urandom));
    end
  endtask

  task automatic waitDones(input int n, input int budget, output bit ok);
    int left;
    left = budget;
    while (doneQ.size() < n && left > 0) begin
      cycle();
      left--;
      if (dropReq && gnt != 2'b00) req = 2'b00;
    end
    ok = (doneQ.size() >= n);
  endtask

  // Reference: each result is the truncated mean of 9 consecutive samples of the owner's frame
  function automatic void addExpected(input bit id, input int start, input int n);
    int sum;
    for (int j = 0; j < n; j++) begin
      sum = 0;
      for (int k = 0; k < TAPS; k++)
        sum += id ? int'(src1[start + j + k]) : int'(src0[start + j + k]);
      expQ.push_back({id, 8'(sum / TAPS)});
    end
  endfunction

  function automatic int firstOutDiff();
    if (outQ.size() != expQ.size()) return -2;
    foreach (outQ[i]) if (outQ[i] !== expQ[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req = 2'b00;
    idle(3);
    total++; if (gnt !== 2'b00) begin bad++; $display("[TB] FAIL reset_gnt: got %0b want 00", gnt); end
    total++; if (avg_rst !== 1'b1) begin bad++; $display("[TB] FAIL reset_avg_rst: got %0b want 1", avg_rst); end
    total++; if (avg_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_avg_data: got %0h want 0", avg_data); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_data: got %0h want 0", out_data); end
    total++; if (out_id !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_id: got %0b want 0", out_id); end
    total++; if (done !== 2'b00) begin bad++; $display("[TB] FAIL reset_done: got %0b want 00", done); end
    total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout: got %0b want 0", timeout); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    reset = 1'b0;
    idle(3);
    total++; if (busy !== 1'b0 || gnt !== 2'b00) begin bad++; $display("[TB] FAIL idle_no_req: got busy=%0b gnt=%0b want 0/00", busy, gnt); end
  endtask

  task automatic test_single_ramp();
    bit ok;
    int startCyc, d, dataBad;
    clearLogs();
    for (int i = 0; i < FRAME_LEN; i++) src0.push_back(8'(i));
    addExpected(1'b0, 0, OUT_LEN);
    dropReq = 1;
    req = 2'b01;
    startCyc = cyc;
    waitDones(1, 400, ok);
    idle(4);
    total++; if (!ok) begin bad++; $display("[TB] FAIL ramp_done_seen: got %0d dones want 1", doneQ.size()); end
    total++; if (gntRiseCyc - startCyc != 2) begin bad++; $display("[TB] FAIL ramp_req_to_gnt: got %0d want 2", gntRiseCyc - startCyc); end
    total++; if (runQ.size() != 1 || runQ[0] != FRAME_LEN) begin bad++; $display("[TB] FAIL ramp_gnt_run: got %0d runs first=%0d want 1 run of %0d", runQ.size(), (runQ.size() > 0) ? runQ[0] : -1, FRAME_LEN); end
    total++; if (gntCnt0 != FRAME_LEN || gntCnt1 != 0) begin bad++; $display("[TB] FAIL ramp_gnt_count: got %0d/%0d want %0d/0", gntCnt0, gntCnt1, FRAME_LEN); end
    dataBad = 0;
    foreach (avgDataQ[i]) if (i < FRAME_LEN && avgDataQ[i] !== 8'(i)) dataBad++;
    total++; if (avgDataQ.size() != FRAME_LEN || dataBad != 0) begin bad++; $display("[TB] FAIL ramp_avg_data: got %0d samples %0d wrong want %0d samples 0 wrong", avgDataQ.size(), dataBad, FRAME_LEN); end
    total++; if (outQ.size() != OUT_LEN) begin bad++; $display("[TB] FAIL ramp_out_count: got %0d want %0d", outQ.size(), OUT_LEN); end
    d = firstOutDiff();
    total++; if (d != -1) begin bad++; $display("[TB] FAIL ramp_out_data: first diff at %0d got %0h want %0h", d, (d >= 0) ? outQ[d] : 9'h0, (d >= 0) ? expQ[d] : 9'h0); end
    total++; if (doneQ.size() != 1 || doneQ[0] !== 2'b01) begin bad++; $display("[TB] FAIL ramp_done: got %0d pulses first=%0b want 1 pulse 01", doneQ.size(), (doneQ.size() > 0) ? doneQ[0] : 2'b00); end
    total++; if (doneCyc - lastOutCyc != 1) begin bad++; $display("[TB] FAIL ramp_done_timing: got %0d want 1", doneCyc - lastOutCyc); end
    total++; if (rstOkQ.size() != 1 || rstOkQ[0] != 1) begin bad++; $display("[TB] FAIL ramp_avg_rst_edge: got %0d want 1", (rstOkQ.size() > 0) ? rstOkQ[0] : 0); end
    total++; if (timeout !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL ramp_end_flags: got timeout=%0b busy=%0b want 0/0", timeout, busy); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int d, rstBad;
    logic [3:0] ord;
    logic [7:0] dp;
    clearLogs();
    fillRandom(1'b0, 2 * FRAME_LEN);
    fillRandom(1'b1, 2 * FRAME_LEN);
    dropReq = 0;
    req = 2'b11;
    resetPulse();
    waitDones(4, 4 * 300, ok);
    req = 2'b00;
    idle(4);
    addExpected(1'b0, 0, OUT_LEN);
    addExpected(1'b1, 0, OUT_LEN);
    addExpected(1'b0, FRAME_LEN, OUT_LEN);
    addExpected(1'b1, FRAME_LEN, OUT_LEN);
    ord = 4'b0000;
    foreach (orderQ[i]) if (i < 4) ord[i] = orderQ[i];
    dp = 8'h00;
    foreach (doneQ[i]) if (i < 4) dp[2*i +: 2] = doneQ[i];
    rstBad = 0;
    foreach (rstOkQ[i]) if (!rstOkQ[i]) rstBad++;
    total++; if (!ok) begin bad++; $display("[TB] FAIL rr_done_seen: got %0d want 4", doneQ.size()); end
    total++; if (orderQ.size() != 4 || ord !== 4'b1010) begin bad++; $display("[TB] FAIL rr_order: got %0d frames order=%0b want 4 frames 1010", orderQ.size(), ord); end
    total++; if (doneQ.size() != 4 || dp !== 8'b10011001) begin bad++; $display("[TB] FAIL rr_done_seq: got %0b want 10011001", dp); end
    total++; if (overlap) begin bad++; $display("[TB] FAIL rr_gnt_overlap: got 1 want 0"); end
    total++; if (rstOkQ.size() != 4 || rstBad != 0) begin bad++; $display("[TB] FAIL rr_avg_rst_pulse: got %0d bad of %0d want 0 of 4", rstBad, rstOkQ.size()); end
    d = firstOutDiff();
    total++; if (d != -1) begin bad++; $display("[TB] FAIL rr_out_data: first diff at %0d got %0d results want %0d", d, outQ.size(), expQ.size()); end
  endtask

  task automatic test_drain_timeout();
    bit ok;
    int d;
    clearLogs();
    resetPulse();
    fillRandom(1'b1, FRAME_LEN);
    resultLimit = 110;
    addExpected(1'b1, 0, 110);
    dropReq = 1;
    req = 2'b10;
    waitDones(1, 400, ok);
    total++; if (!ok || doneQ[0] !== 2'b10) begin bad++; $display("[TB] FAIL drain_done: got %0d pulses want 1 pulse 10", doneQ.size()); end
    total++; if (timeout !== 1'b1) begin bad++; $display("[TB] FAIL drain_timeout_set: got %0b want 1", timeout); end
    total++; if (doneCyc - gntFallCyc != DRAIN_MAX) begin bad++; $display("[TB] FAIL drain_length: got %0d want %0d", doneCyc - gntFallCyc, DRAIN_MAX); end
    idle(6);
    total++; if (outQ.size() != 110) begin bad++; $display("[TB] FAIL drain_out_count: got %0d want 110", outQ.size()); end
    d = firstOutDiff();
    total++; if (d != -1) begin bad++; $display("[TB] FAIL drain_out_data: first diff at %0d", d); end
    total++; if (timeout !== 1'b1) begin bad++; $display("[TB] FAIL drain_timeout_sticky: got %0b want 1", timeout); end
    resultLimit = OUT_LEN;
  endtask

  task automatic test_extra_results();
    bit ok1, ok2;
    int d;
    logic [3:0] dp;
    clearLogs();
    resetPulse();
    fillRandom(1'b0, FRAME_LEN);
    fillRandom(1'b1, FRAME_LEN);
    extraCount = 5;
    dropReq = 1;
    req = 2'b01;
    waitDones(1, 400, ok1);
    idle(12);
    extraCount = 0;
    req = 2'b10;
    waitDones(2, 400, ok2);
    idle(4);
    addExpected(1'b0, 0, OUT_LEN);
    addExpected(1'b1, 0, OUT_LEN);
    dp = 4'b0000;
    foreach (doneQ[i]) if (i < 2) dp[2*i +: 2] = doneQ[i];
    total++; if (!ok1 || !ok2 || dp !== 4'b1001) begin bad++; $display("[TB] FAIL extra_done_seq: got %0b want 1001", dp); end
    total++; if (outQ.size() != 2 * OUT_LEN) begin bad++; $display("[TB] FAIL extra_out_count: got %0d want %0d", outQ.size(), 2 * OUT_LEN); end
    d = firstOutDiff();
    total++; if (d != -1) begin bad++; $display("[TB] FAIL extra_out_data: first diff at %0d", d); end
    total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL extra_timeout: got %0b want 0", timeout); end
  endtask

  task automatic test_midframe_reset();
    bit okA, okB;
    int left, d;
    clearLogs();
    resetPulse();
    fillRandom(1'b0, 2 * FRAME_LEN);
    fillRandom(1'b1, FRAME_LEN);
    dropReq = 1;
    req = 2'b01;
    waitDones(1, 400, okA);
    idle(3);
    dropReq = 0;
    req = 2'b11;
    left = 300;
    while (gntCnt1 < 60 && left > 0) begin cycle(); left--; end
    total++; if (!okA || gntCnt1 != 60) begin bad++; $display("[TB] FAIL mid_reach_sample60: got %0d want 60", gntCnt1); end
    reset = 1'b1;
    cycle();
    total++; if (gnt !== 2'b00 || avg_rst !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_state: got gnt=%0b avg_rst=%0b busy=%0b want 00/1/0", gnt, avg_rst, busy); end
    total++; if (done !== 2'b00 || doneQ.size() != 1) begin bad++; $display("[TB] FAIL mid_reset_no_done: got done=%0b pulses=%0d want 00/1", done, doneQ.size()); end
    reset = 1'b0;
    outQ.delete();
    expQ.delete();
    addExpected(1'b0, FRAME_LEN, OUT_LEN);
    dropReq = 1;
    waitDones(2, 400, okB);
    idle(4);
    total++; if (!okB || orderQ.size() != 3 || orderQ[1] != 1 || orderQ[2] != 0) begin bad++; $display("[TB] FAIL mid_restart_owner: got %0d frames want owners 0,1,0", orderQ.size()); end
    total++; if (doneQ.size() != 2 || doneQ[1] !== 2'b01) begin bad++; $display("[TB] FAIL mid_restart_done: got %0d pulses want 2", doneQ.size()); end
    d = firstOutDiff();
    total++; if (d != -1) begin bad++; $display("[TB] FAIL mid_restart_data: first diff at %0d got %0d results", d, outQ.size()); end
  endtask

  task automatic test_idle_valid();
    bit ok;
    int d;
    clearLogs();
    resetPulse();
    fillRandom(1'b0, FRAME_LEN);
    addExpected(1'b0, 0, OUT_LEN);
    forceValid = 1;
    idle(6);
    total++; if (outQ.size() != 0) begin bad++; $display("[TB] FAIL idle_valid_dropped: got %0d want 0", outQ.size()); end
    dropReq = 1;
    req = 2'b01;
    cycle();
    forceValid = 0;
    cycle();
    total++; if (outQ.size() != 0) begin bad++; $display("[TB] FAIL clear_valid_dropped: got %0d want 0", outQ.size()); end
    total++; if (gnt !== 2'b01 || busy !== 1'b1) begin bad++; $display("[TB] FAIL clear_to_stream: got gnt=%0b busy=%0b want 01/1", gnt, busy); end
    waitDones(1, 400, ok);
    idle(4);
    d = firstOutDiff();
    total++; if (!ok || d != -1) begin bad++; $display("[TB] FAIL idle_frame_data: done=%0b first diff at %0d", ok, d); end
  endtask

  initial begin
    test_reset();
    test_single_ramp();
    test_round_robin();
    test_drain_timeout();
    test_extra_results();
    test_midframe_reset();
    test_idle_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
